// File: rtl/loproc_shift_ex.sv
// Two-stage shift/rotate execute stage (S1 operation reg, S2 result reg), valid/ready both sides.
// Optional {C,N,Z} flag output compiled in with `define LOPROC_SHIFT_FLAGS_EN.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_LOG2
`define DATA_LOG2 5
`endif

module loproc_shifter32 (
    input  logic [`DATA_WIDTH-1:0] i_data,
    input  logic [`DATA_LOG2-1:0]  i_shamt,
    input  logic                   i_lrn,
    input  logic                   i_srn,
    input  logic                   i_aln,
    output logic [`DATA_WIDTH-1:0] o_result,
    output logic                   o_carry
);
    logic signed [`DATA_WIDTH-1:0] w_sdata;
    logic [`DATA_LOG2-1:0]         w_inv;
    logic [`DATA_LOG2-1:0]         w_ridx;

    assign w_sdata = $signed(i_data);
    // 0 - shamt wraps to 32 - shamt, which is all that is needed for shamt != 0
    assign w_inv   = '0 - i_shamt;
    assign w_ridx  = i_shamt - 1'b1;

    always_comb begin
        o_result = i_data;
        o_carry  = 1'b0;
        if (i_shamt != '0) begin
            if (i_lrn) begin
                o_result = i_data << i_shamt;
                if (!i_srn)
                    o_result = o_result | (i_data >> w_inv);
                o_carry = i_data[w_inv];
            end else begin
                if (!i_srn)
                    o_result = (i_data >> i_shamt) | (i_data << w_inv);
                else if (i_aln)
                    o_result = $unsigned(w_sdata >>> i_shamt);
                else
                    o_result = i_data >> i_shamt;
                o_carry = i_data[w_ridx];
            end
        end
    end
endmodule

module loproc_shift_ex (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`DATA_WIDTH-1:0] in_data,
    input  logic [`DATA_LOG2-1:0]  in_shamt,
    input  logic                   in_LRn,
    input  logic                   in_SRn,
    input  logic                   in_ALn,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`DATA_WIDTH-1:0] out_data
`ifdef LOPROC_SHIFT_FLAGS_EN
    ,
    output logic [2:0]             out_flags
`endif
);
    logic                   r_s1_valid;
    logic [`DATA_WIDTH-1:0] r_s1_data;
    logic [`DATA_LOG2-1:0]  r_s1_shamt;
    logic                   r_s1_lrn;
    logic                   r_s1_srn;
    logic                   r_s1_aln;
    logic                   r_out_valid;
    logic [`DATA_WIDTH-1:0] r_out_data;

    logic                   w_s1_adv;
    logic                   w_accept;
    logic [`DATA_WIDTH-1:0] w_result;

    // in_ready looks only at pipeline state and out_ready, never at in_valid
    assign w_s1_adv  = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef LOPROC_SHIFT_FLAGS_EN
    logic       w_carry;
    logic [2:0] r_out_flags;
    assign out_flags = r_out_flags;
`else
    logic       w_carry_unused;
`endif

    loproc_shifter32 u_shifter (
        .i_data   (r_s1_data),
        .i_shamt  (r_s1_shamt),
        .i_lrn    (r_s1_lrn),
        .i_srn    (r_s1_srn),
        .i_aln    (r_s1_aln),
        .o_result (w_result),
`ifdef LOPROC_SHIFT_FLAGS_EN
        .o_carry  (w_carry)
`else
        .o_carry  (w_carry_unused)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_shamt  <= '0;
            r_s1_lrn    <= 1'b0;
            r_s1_srn    <= 1'b0;
            r_s1_aln    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= in_data;
                r_s1_shamt <= in_shamt;
                r_s1_lrn   <= in_LRn;
                r_s1_srn   <= in_SRn;
                r_s1_aln   <= in_ALn;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef LOPROC_SHIFT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_out_flags <= 3'b000;
        else if (w_s1_adv)
            r_out_flags <= {w_carry, w_result[`DATA_WIDTH-1], (w_result == '0)};
    end
`endif
endmodule
